// File: rtl/mem_trace_buffer.sv
// mem_trace_buffer: windowed RAM access capture with timestamps into a drop/wrap FIFO drained over valid/ready
module mem_trace_buffer #(
  parameter int ADDR_W        = 15,
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 16,
  parameter int TS_W          = 32,
  parameter int CAPTURE_READS = 0,
  parameter int WRAP_MODE     = 0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     En,
  input  logic                     Clear,
  input  logic [ADDR_W-1:0]        AddrLo,
  input  logic [ADDR_W-1:0]        AddrHi,
  input  logic                     We,
  input  logic                     Re,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [DATA_W-1:0]        RdData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [TS_W-1:0]          OutTs,
  output logic                     OutWrite,
  output logic [ADDR_W-1:0]        OutAddr,
  output logic [DATA_W-1:0]        OutData,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic [15:0]              DropCnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [TS_W-1:0]   ts_mem_q   [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0]  wr_mem_q;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;
  logic [DATA_W-1:0] data_d;
  logic              ev, full, pop, lost, push;
  always_comb begin
    ev     = En && (We || (Re && CAPTURE_READS != 0)) && Address >= AddrLo && Address <= AddrHi;
    full   = cnt_q == CW'(DEPTH);
    pop    = cnt_q != '0 && OutReady;
    lost   = ev && full && !pop;
    push   = ev && (!lost || WRAP_MODE != 0);
    data_d = We ? WrData : RdData;
    ts_d   = Clear ? '0 : ts_q + TS_W'(1);
    rd_d   = Clear ? '0 : rd_q + PW'(pop || (lost && WRAP_MODE != 0));
    wr_d   = Clear ? '0 : wr_q + PW'(push);
    cnt_d  = Clear ? '0 : cnt_q + CW'(push && !pop && !full) - CW'(pop && !push);
    ovf_d  = !Clear && (ovf_q || lost);
    drop_d = Clear ? '0 : drop_q + 16'(lost && drop_q != 16'hFFFF);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ts_q   <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (push) begin
      ts_mem_q[wr_q]   <= ts_q;
      addr_mem_q[wr_q] <= Address;
      data_mem_q[wr_q] <= data_d;
      wr_mem_q[wr_q]   <= We;
    end
  end
  always_comb begin
    OutValid = cnt_q != '0;
    OutTs    = OutValid ? ts_mem_q[rd_q] : '0;
    OutWrite = OutValid && wr_mem_q[rd_q];
    OutAddr  = OutValid ? addr_mem_q[rd_q] : '0;
    OutData  = OutValid ? data_mem_q[rd_q] : '0;
    Count    = cnt_q;
    Overflow = ovf_q;
    DropCnt  = drop_q;
  end
endmodule

// File: tb/tb_mem_trace_buffer.sv
// tb_mem_trace_buffer: directed table and sequence checks of drop-mode and wrap/read-capture instances
module tb_mem_trace_buffer;
  logic        Clk = 1'b0;
  logic        Reset, En, Clear, We, Re, OutReady;
  logic [14:0] AddrLo, AddrHi, Address;
  logic [15:0] WrData, RdData;
  logic        v0, w0, ovf0, v1, w1, ovf1;
  logic [31:0] ts0, ts1;
  logic [14:0] a0, a1;
  logic [15:0] d0, d1, dc0, dc1;
  logic [4:0]  c0, c1;
  int errs = 0;
  int checks = 0;
  always #5 Clk = ~Clk;
  mem_trace_buffer #(.DEPTH(16), .CAPTURE_READS(0), .WRAP_MODE(0)) u0 (
    .Clk(Clk), .Reset(Reset), .En(En), .Clear(Clear), .AddrLo(AddrLo), .AddrHi(AddrHi),
    .We(We), .Re(Re), .Address(Address), .WrData(WrData), .RdData(RdData),
    .OutValid(v0), .OutReady(OutReady), .OutTs(ts0), .OutWrite(w0), .OutAddr(a0),
    .OutData(d0), .Count(c0), .Overflow(ovf0), .DropCnt(dc0));
  mem_trace_buffer #(.DEPTH(16), .CAPTURE_READS(1), .WRAP_MODE(1)) u1 (
    .Clk(Clk), .Reset(Reset), .En(En), .Clear(Clear), .AddrLo(AddrLo), .AddrHi(AddrHi),
    .We(We), .Re(Re), .Address(Address), .WrData(WrData), .RdData(RdData),
    .OutValid(v1), .OutReady(OutReady), .OutTs(ts1), .OutWrite(w1), .OutAddr(a1),
    .OutData(d1), .Count(c1), .Overflow(ovf1), .DropCnt(dc1));
  typedef struct {
    int clr, en, we, re, rdy, lo, hi, addr, wd, rd;
    int c0, a0, d0, c1;
  } vec_t;
  vec_t v [11];
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle();
    En = 1; We = 0; Re = 0; Clear = 0; OutReady = 0;
    AddrLo = 15'd0; AddrHi = 15'h7FFF; Address = 15'd0; WrData = 16'd0; RdData = 16'd0;
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic wr(input int addr, input int data);
    We = 1; Address = 15'(addr); WrData = 16'(data);
    step();
    We = 0;
  endtask
  task automatic clr();
    Clear = 1;
    step();
    Clear = 0;
  endtask
  initial begin
    v[0]  = '{1, 1, 0, 0, 0, 16, 31, 0,  0,      0,      0, 0,  0,      0};
    v[1]  = '{0, 1, 1, 0, 0, 16, 31, 15, 'h15,   0,      0, 0,  0,      0};
    v[2]  = '{0, 1, 1, 0, 0, 16, 31, 16, 'h16,   0,      1, 16, 'h16,   1};
    v[3]  = '{0, 1, 1, 0, 0, 16, 31, 31, 'h31,   0,      2, 16, 'h16,   2};
    v[4]  = '{0, 1, 1, 0, 0, 16, 31, 32, 'h32,   0,      2, 16, 'h16,   2};
    v[5]  = '{0, 1, 0, 1, 0, 16, 31, 20, 0,      'hBEEF, 2, 16, 'h16,   3};
    v[6]  = '{0, 1, 1, 0, 0, 40, 10, 20, 'h77,   0,      2, 16, 'h16,   3};
    v[7]  = '{0, 1, 1, 0, 0, 40, 10, 40, 'h78,   0,      2, 16, 'h16,   3};
    v[8]  = '{0, 0, 1, 0, 0, 16, 31, 20, 'h79,   0,      2, 16, 'h16,   3};
    v[9]  = '{0, 1, 0, 0, 1, 16, 31, 0,  0,      0,      1, 31, 'h31,   2};
    v[10] = '{0, 1, 0, 0, 1, 16, 31, 0,  0,      0,      0, 0,  0,      1};
    idle();
    Reset = 1;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 0;
    chk("rst_valid0", v0, 0); chk("rst_count0", c0, 0); chk("rst_ovf0", ovf0, 0); chk("rst_drop0", dc0, 0);
    chk("rst_valid1", v1, 0); chk("rst_count1", c1, 0);
    repeat (5) step();
    wr(16, 7);
    chk("cap_valid", v0, 1); chk("cap_write", w0, 1); chk("cap_addr", a0, 16);
    chk("cap_data", d0, 7); chk("cap_ts", ts0, 5); chk("cap_count", c0, 1);
    OutReady = 1;
    step();
    OutReady = 0;
    chk("cap_pop_count", c0, 0);
    for (int i = 0; i < 11; i++) begin
      Clear = v[i].clr != 0; En = v[i].en != 0; We = v[i].we != 0; Re = v[i].re != 0;
      OutReady = v[i].rdy != 0; AddrLo = 15'(v[i].lo); AddrHi = 15'(v[i].hi);
      Address = 15'(v[i].addr); WrData = 16'(v[i].wd); RdData = 16'(v[i].rd);
      step();
      chk($sformatf("vec%0d_count0", i), c0, v[i].c0);
      chk($sformatf("vec%0d_valid0", i), v0, v[i].c0 != 0);
      chk($sformatf("vec%0d_addr0", i), a0, v[i].a0);
      chk($sformatf("vec%0d_data0", i), d0, v[i].d0);
      chk($sformatf("vec%0d_count1", i), c1, v[i].c1);
    end
    idle();
    chk("rd_entry_write1", w1, 0); chk("rd_entry_addr1", a1, 20); chk("rd_entry_data1", d1, 'hBEEF);
    clr();
    for (int i = 0; i < 20; i++) wr(100 + i, i);
    chk("ovf_count0", c0, 16); chk("ovf_count1", c1, 16);
    chk("ovf_flag0", ovf0, 1); chk("ovf_flag1", ovf1, 1);
    chk("ovf_drop0", dc0, 4); chk("ovf_drop1", dc1, 4);
    OutReady = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_data0", i), d0, i);
      chk($sformatf("drain%0d_data1", i), d1, i + 4);
      step();
    end
    OutReady = 0;
    chk("drain_count0", c0, 0); chk("drain_count1", c1, 0);
    clr();
    chk("clr_ovf0", ovf0, 0); chk("clr_drop0", dc0, 0); chk("clr_drop1", dc1, 0);
    for (int i = 0; i < 16; i++) wr(200 + i, i);
    OutReady = 1;
    wr(300, 'h99);
    OutReady = 0;
    chk("fullpp_count0", c0, 16); chk("fullpp_count1", c1, 16);
    chk("fullpp_drop0", dc0, 0); chk("fullpp_drop1", dc1, 0);
    chk("fullpp_ovf0", ovf0, 0); chk("fullpp_head0", d0, 1);
    Clear = 1;
    wr(301, 'h55);
    Clear = 0;
    chk("clrwr_count0", c0, 0); chk("clrwr_valid0", v0, 0); chk("clrwr_count1", c1, 0);
    step();
    wr(9, 5);
    chk("clr_ts0", ts0, 1); chk("clr_ts_count0", c0, 1);
    clr();
    We = 1; Re = 1; Address = 15'd5; WrData = 16'h1111; RdData = 16'h2222;
    step();
    chk("wre_count1", c1, 1); chk("wre_write1", w1, 1); chk("wre_data1", d1, 'h1111);
    chk("wre_drop1", dc1, 0); chk("wre_count0", c0, 1);
    We = 0; Re = 1; Address = 15'd6; RdData = 16'h3333;
    step();
    chk("rd_count1", c1, 2); chk("rd_count0", c0, 1);
    Re = 0; OutReady = 1;
    step();
    chk("rd_head_write1", w1, 0); chk("rd_head_data1", d1, 'h3333); chk("rd_head_count0", c0, 0);
    Reset = 1; We = 1; Address = 15'd7;
    step();
    Reset = 0;
    idle();
    chk("rstmid_count1", c1, 0); chk("rstmid_valid1", v1, 0); chk("rstmid_data1", d1, 0);
    chk("rstmid_count0", c0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
